wb_seq_gcd: RTL
===============

Name: wb_seq_gcd

Overview:
Parametrised, Wishbone-controlled sequential GCD engine for the user project area. It computes gcd(A,B) on WIDTH-bit unsigned operands using binary (Stein) iteration, one step per clock, so no divider or modulo unit is needed. Software writes the operands, starts the engine, then polls or takes an interrupt. The result is also mirrored on a parallel output for IO/LA observation.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 8..32.

Ports:
wb_clk_i  in  1  single clock.
wb_rst_i  in  1  asynchronous, active-high reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  write enable.
wbs_sel_i  in  4  byte enables, writes only.
wbs_dat_i  in  32  write data.
wbs_adr_i  in  32  address; only [4:2] decoded, upper bits decoded by the wrapper.
wbs_ack_o  out  1  transfer acknowledge.
wbs_dat_o  out  32  read data.
irq_o  out  1  done interrupt, level.
busy_o  out  1  engine running.
gcd_o  out  WIDTH  last result, registered.

Behaviour:
- Reset is asynchronous, active-high, and applies to all registers. Reset values: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, busy_o=0, gcd_o=0. Operand, result, control and state registers are 0 and the state is IDLE.
- Wishbone handshake:
  - A transfer is requested when cyc&stb.
  - ack=1 in the cycle after the request is seen with ack=0. ack is a one-cycle pulse; a held request gets exactly one ack per transfer.
  - Writes take effect at the edge that raises ack. Read data is registered and valid together with ack.
- Register map (byte offsets):
  - 0x00 CTRL. Bit 0 START: write 1 to start; self-clearing, reads 0. Bit 1 BUSY: read-only. Bit 2 DONE: read-only, write 1 to clear. Bit 3 IRQ_EN: read/write.
  - 0x04 A and 0x08 B: read/write with byte enables. Bits at or above WIDTH are ignored on write and read as 0.
  - 0x0C RESULT: read-only.
  - 0x10 CYCLES: see Optional Feature.
  - 0x14-0x1C: read as 0; writes ignored.
- State machine IDLE -> RUN -> IDLE:
  - IDLE: a START write loads working registers a=A, b=B, k=0, clears DONE and enters RUN at the same edge. busy_o=1 from the next cycle.
  - RUN, one action per cycle, in priority order:
    - a==0: result=b<<k; exit.
    - b==0: result=a<<k; exit.
    - a and b both even: a>>=1, b>>=1, k++.
    - a even: a>>=1.
    - b even: b>>=1.
    - both odd: a>=b ? a=a-b : b=b-a.
  - Exit from RUN: RESULT and gcd_o update, DONE=1, state returns to IDLE. busy_o=0 in the following cycle.
- Arithmetic and timing bounds:
  - k is $clog2(WIDTH)+1 bits.
  - The result never exceeds max(A,B), so no overflow is possible.
  - Worst-case RUN length is at most 4*WIDTH cycles.
- Boundary cases:
  - A=0 or B=0: result is the other operand; 1 RUN cycle.
  - A=B=0: result 0, DONE=1.
  - A==B: subtract step, then the zero check; result A.
- Simultaneous events:
  - START write while in RUN is ignored. The current operation continues; DONE is not cleared.
  - A/B writes during RUN update the operand registers only; the active operation is unaffected.
  - DONE W1C in the same cycle as RUN exit: set wins.
- irq_o = DONE & IRQ_EN, registered.
- Reset asserted mid-operation: immediate return to IDLE, with all values at reset.

Optional Feature:
GCD_CYCLE_CNT_EN
- Defined: a 32-bit CYCLES register at 0x10, read-only. It is cleared on START and increments every RUN cycle, holding the count of the last operation; it saturates at 0xFFFFFFFF.
- Undefined: no counter logic; 0x10 reads 0 and writes are ignored.

Test Plan:
- A=48, B=18, START, poll -> RESULT=6, gcd_o=6, DONE=1, BUSY=0; exactly one ack per transfer.
- A=0, B=35 -> RESULT=35 after 1 RUN cycle. A=B=0 -> RESULT=0, DONE=1. With GCD_CYCLE_CNT_EN -> CYCLES=1 in both cases.
- WIDTH=32: A=0x80000000, B=0x00100000 -> 0x00100000. A=0xFFFFFFFF, B=0xFFFFFFFE -> 1; RUN length at most 128 cycles.
- IRQ_EN=1, A=12, B=8 -> irq_o rises after DONE, RESULT=4. Write 0x4 to CTRL -> DONE=0, irq_o=0 on the next cycle.
- A=1071, B=462, START; during RUN write A=5 and START -> ignored, RESULT=21. A reads back 5.
- Start A=1071, B=462; assert wb_rst_i mid-RUN -> busy_o=0, gcd_o=0, A/B/RESULT=0 immediately. After release, a new operation with A=48, B=18 completes -> 6.

Source files
------------

// File: rtl/wb_seq_gcd.sv
// wb_seq_gcd: Wishbone-controlled binary (Stein) GCD engine; define GCD_CYCLE_CNT_EN to add the CYCLES counter at 0x10
module wb_seq_gcd #(
  parameter int WIDTH = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [31:0]      wbs_adr_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  output logic             irq_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] gcd_o
);
  localparam int KW = $clog2(WIDTH) + 1;
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t           r_state, w_state_n;
  logic             r_ack, r_done, r_irq_en, r_irq;
  logic [31:0]      r_dat, w_rdata, w_cyc;
  logic [WIDTH-1:0] r_a, r_b, r_wa, r_wb, r_res;
  logic [WIDTH-1:0] w_a_n, w_b_n, w_wa_n, w_wb_n, w_res_n;
  logic [KW-1:0]    r_k, w_k_n;
  logic [2:0]       w_adr;
  logic             w_acc, w_wr, w_ctrl_wr, w_start, w_clr, w_exit, w_unused;
  assign w_adr     = wbs_adr_i[4:2];
  assign w_acc     = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr      = w_acc & wbs_we_i;
  assign w_ctrl_wr = w_wr & (w_adr == 3'd0) & wbs_sel_i[0];
  assign w_start   = w_ctrl_wr & wbs_dat_i[0] & (r_state == S_IDLE);
  assign w_clr     = w_ctrl_wr & wbs_dat_i[2];
  assign w_unused  = ^{wbs_adr_i[31:5], wbs_adr_i[1:0]};
  assign busy_o    = (r_state == S_RUN);
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;
  assign gcd_o     = r_res;
  // Byte-enable merge of write data into the operand registers
  always_comb begin
    w_a_n = r_a;
    w_b_n = r_b;
    for (int i = 0; i < WIDTH; i++) begin
      if (wbs_sel_i[i/8]) begin
        w_a_n[i] = wbs_dat_i[i];
        w_b_n[i] = wbs_dat_i[i];
      end
    end
  end
  // Read mux; unused offsets read as zero
  always_comb begin
    w_rdata = (w_adr == 3'd0) ? {28'b0, r_irq_en, r_done, busy_o, 1'b0} :
              (w_adr == 3'd1) ? 32'(r_a) :
              (w_adr == 3'd2) ? 32'(r_b) :
              (w_adr == 3'd3) ? 32'(r_res) :
              (w_adr == 3'd4) ? w_cyc : 32'd0;
  end
  // Next-state and one Stein step per RUN cycle, zero checks first
  always_comb begin
    w_state_n = r_state;
    w_wa_n    = r_wa;
    w_wb_n    = r_wb;
    w_k_n     = r_k;
    w_res_n   = r_res;
    w_exit    = 1'b0;
    if (r_state == S_IDLE) begin
      if (w_start) begin
        w_state_n = S_RUN;
        w_wa_n    = r_a;
        w_wb_n    = r_b;
        w_k_n     = '0;
      end
    end else if (r_wa == '0 || r_wb == '0) begin
      w_exit    = 1'b1;
      w_state_n = S_IDLE;
      w_res_n   = ((r_wa == '0) ? r_wb : r_wa) << r_k;
    end else if (!r_wa[0] && !r_wb[0]) begin
      w_wa_n = r_wa >> 1;
      w_wb_n = r_wb >> 1;
      w_k_n  = r_k + 1'b1;
    end else if (!r_wa[0]) begin
      w_wa_n = r_wa >> 1;
    end else if (!r_wb[0]) begin
      w_wb_n = r_wb >> 1;
    end else if (r_wa >= r_wb) begin
      w_wa_n = r_wa - r_wb;
    end else begin
      w_wb_n = r_wb - r_wa;
    end
  end
  // Engine state and working registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_wa    <= '0;
      r_wb    <= '0;
      r_k     <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_n;
      r_wa    <= w_wa_n;
      r_wb    <= w_wb_n;
      r_k     <= w_k_n;
      r_res   <= w_res_n;
    end
  end
  // Bus handshake, operand/control registers; DONE set beats W1C
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_done   <= 1'b0;
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_ack    <= w_acc;
      r_dat    <= (w_acc & ~wbs_we_i) ? w_rdata : 32'd0;
      r_a      <= (w_wr && w_adr == 3'd1) ? w_a_n : r_a;
      r_b      <= (w_wr && w_adr == 3'd2) ? w_b_n : r_b;
      r_irq_en <= w_ctrl_wr ? wbs_dat_i[3] : r_irq_en;
      r_done   <= w_exit ? 1'b1 : (w_start | w_clr) ? 1'b0 : r_done;
      r_irq    <= r_done & r_irq_en;
    end
  end
`ifdef GCD_CYCLE_CNT_EN
  logic [31:0] r_cyc;
  // Saturating count of RUN cycles of the last operation
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_cyc <= '0;
    else if (w_start) r_cyc <= '0;
    else if (busy_o && r_cyc != '1) r_cyc <= r_cyc + 32'd1;
  end
  assign w_cyc = r_cyc;
`else
  assign w_cyc = 32'd0;
`endif
endmodule
